// File: rtl/dcache_2way.sv
// Two-way set-associative, write-through, no-write-allocate data cache with req/ack memory port.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_2way #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           SET_BITS     = 3,
    parameter logic [ADDR_WIDTH-1:0] UNCACHED_TOP = 32'h0000_00FF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int unsigned TAG_W = ADDR_WIDTH - SET_BITS - 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        WRITE  = 3'd2,
        UNC_RD = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [(1<<SET_BITS)-1:0] valid_q [2];
    logic [(1<<SET_BITS)-1:0] lru_q;
    logic [TAG_W-1:0]         tag_q   [2][1<<SET_BITS];
    logic [DATA_WIDTH-1:0]    data_q  [2][1<<SET_BITS];

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_wstrb_q, mem_wstrb_d;
    logic [DATA_WIDTH-1:0] hold_q;

    logic [SET_BITS-1:0]   idx;
    logic [TAG_W-1:0]      tag;
    logic                  uncached;
    logic                  hit0, hit1, hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  victim;
    logic [DATA_WIDTH-1:0] merged;
    logic                  load_hit, fill_we, store_upd, hold_we;

    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [2:0] f3,
                                                       input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = w;
            3'b100:  load_ext = {24'b0, b};
            3'b101:  load_ext = {16'b0, h};
            default: load_ext = '0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  store_strb = 4'b0001 << a;
            3'b001:  store_strb = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  store_strb = 4'b1111;
            default: store_strb = 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [2:0] f3,
                                                         input logic [1:0] a);
        case (f3)
            3'b000:  store_data = {24'b0, d[7:0]} << {a, 3'b000};
            3'b001:  store_data = a[1] ? {d[15:0], 16'b0} : {16'b0, d[15:0]};
            3'b010:  store_data = d;
            default: store_data = '0;
        endcase
    endfunction

    assign idx      = addr[SET_BITS+1:2];
    assign tag      = addr[ADDR_WIDTH-1:SET_BITS+2];
    assign uncached = (addr <= UNCACHED_TOP);
    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag) && !uncached;
    assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag) && !uncached;
    assign hit      = hit0 || hit1;
    assign hit_data = hit1 ? data_q[1][idx] : data_q[0][idx];

    // Prefer an empty way (way 0 first); only fall back to LRU when both are valid.
    assign victim = !valid_q[0][idx] ? 1'b0 :
                    !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    always_comb begin
        merged = hit_data;
        if (mem_wstrb_q[0]) merged[7:0]   = mem_wdata_q[7:0];
        if (mem_wstrb_q[1]) merged[15:8]  = mem_wdata_q[15:8];
        if (mem_wstrb_q[2]) merged[23:16] = mem_wdata_q[23:16];
        if (mem_wstrb_q[3]) merged[31:24] = mem_wdata_q[31:24];
    end

    always_comb begin
        state_d     = state_q;
        load_hit    = 1'b0;
        fill_we     = 1'b0;
        store_upd   = 1'b0;
        hold_we     = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (we)            state_d = WRITE;
                    else if (uncached) state_d = UNC_RD;
                    else if (hit)      load_hit = 1'b1;
                    else               state_d = FILL;
                    if (state_d != IDLE) begin
                        mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_we_d    = we;
                        mem_wstrb_d = we ? store_strb(funct3, addr[1:0]) : 4'b0000;
                        mem_wdata_d = we ? store_data(wdata, funct3, addr[1:0]) : '0;
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    store_upd = hit;
                    state_d   = RESP;
                end
            end
            UNC_RD: begin
                if (mem_ack) begin
                    hold_we = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d == FILL) || (state_d == WRITE) || (state_d == UNC_RD);
        stall = ((state_q == IDLE) && req && (we || !hit || uncached)) ||
                ((state_q != IDLE) && (state_q != RESP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            hold_q      <= '0;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if (hold_we) hold_q <= mem_rdata;
            if (fill_we) valid_q[victim][idx] <= 1'b1;
            if (load_hit || store_upd) lru_q[idx] <= !hit1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= mem_rdata;
        end
        if (!rst && store_upd) data_q[hit1][idx] <= merged;
    end

    assign rdata     = load_ext((state_q == RESP) ? hold_q : hit_data, funct3, addr[1:0]);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        miss_evt;

    assign miss_evt = (state_q == IDLE) && (state_d == FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (load_hit && (hit_cnt_q != '1))  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: scoreboarded load data, stall lengths, memory-port fields and counters.
module tb_dcache_2way;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  funct3;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] hit_count, miss_count;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic [31:0] exp_q [$];

    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;
    logic        seen_we;
    logic        found;

    localparam int K_HIT = 0, K_MISS = 1, K_STORE = 2, K_UNC = 3;

    always #5 clk = ~clk;

    dcache_2way dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_counts(input string name);
`ifdef DCACHE_STATS_EN
        check({name, ":hit_count"}, hit_count, exp_hits);
        check({name, ":miss_count"}, miss_count, exp_miss);
`else
        check({name, ":hit_count"}, hit_count, 32'd0);
        check({name, ":miss_count"}, miss_count, 32'd0);
`endif
    endtask

    // One CPU access; memory acks n_ack cycles after mem_req rises with ack_data.
    task automatic access(input string name, input int kind, input logic w,
                          input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                          input int n_ack, input logic [31:0] ack_data, input logic [31:0] exp_rd);
        int   stalls = 0;
        int   mcyc   = 0;
        logic done   = 1'b0;
        logic acked  = 1'b0;
        logic [31:0] e;
        req = 1'b1; we = w; addr = a; wdata = wd; funct3 = f3;
        if (!w) exp_q.push_back(exp_rd);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                seen_addr = mem_addr; seen_we = mem_we;
                seen_wdata = mem_wdata; seen_wstrb = mem_wstrb;
                if (!acked && mcyc == n_ack) begin
                    mem_ack = 1'b1; mem_rdata = ack_data; acked = 1'b1;
                end
                mcyc++;
            end
            if (!stall) begin
                done = 1'b1;
                if (!w && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({name, ":rdata"}, rdata, e);
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1 mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        end
        req = 1'b0;
        check({name, ":done"}, {31'b0, done}, 32'd1);
        check({name, ":stall_cycles"}, stalls, (kind == K_HIT) ? 0 : n_ack + 2);
        if (kind == K_HIT) exp_hits++;
        if (kind == K_MISS) begin exp_miss++; exp_hits++; end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; funct3 = 3'b010;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst:stall", {31'b0, stall}, 32'd0);
        check("rst:mem_req", {31'b0, mem_req}, 32'd0);
        check("rst:mem_we", {31'b0, mem_we}, 32'd0);
        check("rst:mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("rst:mem_addr", mem_addr, 32'd0);
        check("rst:mem_wdata", mem_wdata, 32'd0);
        check_counts("rst");
        @(posedge clk); #1;

        // Load miss then hit
        access("lw_miss", K_MISS, 1'b0, 32'h0001_0000, '0, 3'b010, 3, 32'h8BAD_F00D, 32'h8BAD_F00D);
        check("lw_miss:mem_addr", seen_addr, 32'h0001_0000);
        check("lw_miss:mem_we", {31'b0, seen_we}, 32'd0);
        access("lw_hit", K_HIT, 1'b0, 32'h0001_0000, '0, 3'b010, 0, '0, 32'h8BAD_F00D);
        check_counts("after_hit");

        // Word store hit, then extension cases
        access("sw_hit", K_STORE, 1'b1, 32'h0001_0000, 32'h80FF_7F01, 3'b010, 1, '0, '0);
        check("sw_hit:wstrb", {28'b0, seen_wstrb}, 32'h0000_000F);
        check("sw_hit:wdata", seen_wdata, 32'h80FF_7F01);
        check("sw_hit:mem_we", {31'b0, seen_we}, 32'd1);
        access("lb", K_HIT, 1'b0, 32'h0001_0003, '0, 3'b000, 0, '0, 32'hFFFF_FF80);
        access("lbu", K_HIT, 1'b0, 32'h0001_0003, '0, 3'b100, 0, '0, 32'h0000_0080);
        access("lh", K_HIT, 1'b0, 32'h0001_0000, '0, 3'b001, 0, '0, 32'h0000_7F01);
        access("lhu", K_HIT, 1'b0, 32'h0001_0002, '0, 3'b101, 0, '0, 32'h0000_80FF);
        access("lh_misalign", K_HIT, 1'b0, 32'h0001_0003, '0, 3'b001, 0, '0, 32'hFFFF_80FF);
        access("bad_f3", K_HIT, 1'b0, 32'h0001_0000, '0, 3'b011, 0, '0, 32'h0000_0000);

        // Byte and halfword store merges
        access("sw_base", K_STORE, 1'b1, 32'h0001_0000, 32'h1122_3344, 3'b010, 0, '0, '0);
        access("sb", K_STORE, 1'b1, 32'h0001_0002, 32'h0000_00AB, 3'b000, 2, '0, '0);
        check("sb:wstrb", {28'b0, seen_wstrb}, 32'h0000_0004);
        check("sb:wdata", seen_wdata, 32'h00AB_0000);
        check("sb:mem_addr", seen_addr, 32'h0001_0000);
        access("lw_after_sb", K_HIT, 1'b0, 32'h0001_0000, '0, 3'b010, 0, '0, 32'h11AB_3344);
        access("sh", K_STORE, 1'b1, 32'h0001_0002, 32'hFFFF_BEEF, 3'b001, 0, '0, '0);
        check("sh:wstrb", {28'b0, seen_wstrb}, 32'h0000_000C);
        check("sh:wdata", seen_wdata, 32'hBEEF_0000);
        access("lw_after_sh", K_HIT, 1'b0, 32'h0001_0000, '0, 3'b010, 0, '0, 32'hBEEF_3344);

        // LRU eviction in set 0 (A already in way 0)
        access("lru_B", K_MISS, 1'b0, 32'h0001_0020, '0, 3'b010, 1, 32'hBBBB_0001, 32'hBBBB_0001);
        access("lru_A", K_HIT, 1'b0, 32'h0001_0000, '0, 3'b010, 0, '0, 32'hBEEF_3344);
        access("lru_C", K_MISS, 1'b0, 32'h0001_0040, '0, 3'b010, 0, 32'hCCCC_0002, 32'hCCCC_0002);
        access("lru_A2", K_HIT, 1'b0, 32'h0001_0000, '0, 3'b010, 0, '0, 32'hBEEF_3344);
        access("lru_B2", K_MISS, 1'b0, 32'h0001_0020, '0, 3'b010, 2, 32'hBBBB_0003, 32'hBBBB_0003);
        check_counts("after_lru");

        // Store miss never allocates
        access("sw_miss", K_STORE, 1'b1, 32'h0001_0008, 32'h1234_5678, 3'b010, 0, '0, '0);
        access("lw_after_swmiss", K_MISS, 1'b0, 32'h0001_0008, '0, 3'b010, 0, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        // Uncached window and its upper boundary
        access("unc1", K_UNC, 1'b0, 32'h0000_00FC, '0, 3'b010, 2, 32'hA1A1_0001, 32'hA1A1_0001);
        check("unc1:mem_addr", seen_addr, 32'h0000_00FC);
        access("unc2", K_UNC, 1'b0, 32'h0000_00FC, '0, 3'b010, 0, 32'hA2A2_0002, 32'hA2A2_0002);
        access("unc_lbu_top", K_UNC, 1'b0, 32'h0000_00FF, '0, 3'b100, 1, 32'hA500_0000, 32'h0000_00A5);
        check("unc_lbu_top:mem_addr", seen_addr, 32'h0000_00FC);
        check_counts("after_unc");
        access("cached_0x100", K_MISS, 1'b0, 32'h0000_0100, '0, 3'b010, 0, 32'h0000_1001, 32'h0000_1001);
        access("cached_0x100_hit", K_HIT, 1'b0, 32'h0000_0100, '0, 3'b010, 0, '0, 32'h0000_1001);
        check_counts("after_boundary");

        // Reset while FILL is waiting for ack
        req = 1'b1; we = 1'b0; addr = 32'h0001_0060; funct3 = 3'b010;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (mem_req) found = 1'b1;
        end
        check("rstfill:mem_req_seen", {31'b0, found}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; req = 1'b0;
        exp_hits = 0; exp_miss = 0;
        @(negedge clk);
        check("rstfill:mem_req", {31'b0, mem_req}, 32'd0);
        check("rstfill:stall", {31'b0, stall}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack:mem_req", {31'b0, mem_req}, 32'd0);
        check_counts("after_rst");
        @(posedge clk); #1;
        access("rstfill_remiss", K_MISS, 1'b0, 32'h0001_0060, '0, 3'b010, 1, 32'h6060_6060, 32'h6060_6060);
        access("rst_A_miss", K_MISS, 1'b0, 32'h0001_0000, '0, 3'b010, 0, 32'h7070_7070, 32'h7070_7070);
        check_counts("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_2way.md
# dcache_2way

Two-way set-associative, write-through, no-write-allocate data cache with a variable-latency req/ack backing-memory port. It sits between the CPU load/store path and main data memory and generalises the earlier single-cycle memory-plus-cache datapath. It adds parametrised depth, LRU replacement, a stall handshake, and an uncached MMIO window. Byte, halfword and word loads and stores are handled inside the block using funct3.

## Interface
- DATA_WIDTH, 32: CPU/memory word width; only 32 is supported.
- ADDR_WIDTH, 32: byte address width.
- SET_BITS, 3: log2 of set count. Index is addr[SET_BITS+1:2]; tag is addr[ADDR_WIDTH-1:SET_BITS+2].
- UNCACHED_TOP, 32'h0000_00FF: addresses <= this value bypass the cache (MMIO).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  CPU access valid; held with addr, we, wdata and funct3 stable while stall=1.
- we  in  1  1 = store, 0 = load.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  store data, right-aligned.
- funct3  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; any other code loads 0 and writes nothing.
- rdata  out  DATA_WIDTH  extended load result; valid when req && !we && !stall.
- stall  out  1  CPU must hold the request.
- mem_req  out  1  memory request; registered.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned address, with addr[1:0] forced to 00.
- mem_wdata  out  DATA_WIDTH  store data, lane-shifted.
- mem_wstrb  out  4  byte enables.
- mem_rdata  in  DATA_WIDTH  fill/read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- hit_count, miss_count  out  32  statistics outputs (see Configuration).

## Operation
- Line size is one word. Each way holds valid, tag and data for every set. Each set has one LRU bit, which names the way to replace next.
- States: IDLE, FILL, WRITE, UNC_RD, RESP.
- **Cached load hit** (IDLE): rdata comes combinationally from the hit way, stall=0, and LRU is set to the other way.
- **Cached load miss**:
  - stall=1; go to FILL.
  - In FILL, mem_req=1, mem_we=0. On mem_ack, write the victim way, then go to IDLE. The victim is the first invalid way (way 0 first), otherwise the LRU way.
  - The held request then hits.
- **Store**, cached or uncached:
  - stall=1; go to WRITE.
  - In WRITE, mem_req=1, mem_we=1 and mem_wstrb is set by size and addr[1:0]: sb 0001<<addr[1:0], sh 0011<<{addr[1],0}, sw 1111.
  - On mem_ack: if the store hits, merge the strobed bytes into the cached word and update LRU. Go to RESP.
  - Store misses never allocate.
- **Uncached load**: go to UNC_RD, which issues mem_req. On mem_ack, capture mem_rdata into a hold register and go to RESP. No allocation occurs.
- **RESP**: stall=0 for one cycle. rdata comes from the hold register; for stores it is don't-care. Return to IDLE.
- **Load extraction**:
  - lb/lbu select lane addr[1:0]; lh/lhu select lane addr[1].
  - Signed codes sign-extend; unsigned codes zero-extend.
  - Misaligned address bits below the access size are ignored.
- **Simultaneous events**: mem_ack in IDLE or RESP is ignored. Both ways hitting cannot occur and is not checked.

## Timing
- Reset clears all valid bits and LRU bits and sets state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, stall=0, hold=0, hit_count=0 and miss_count=0. mem_addr and mem_wdata reset to 0.
- Reset mid-transaction abandons the access: mem_req=0 on the next cycle and a late mem_ack is ignored.
- mem_req rises one cycle after the request is accepted. It stays high through the ack cycle and falls on the following edge.
- Load-hit latency is 0 cycles.
- With an ack arriving N cycles after mem_req rises (N>=0):
  - Load miss stalls for N+2 cycles.
  - Store stalls for N+2 cycles.
  - Uncached load stalls for N+2 cycles.
- stall is combinational: (state==IDLE && req && (we || miss || uncached)) || state∉{IDLE,RESP}.

## Configuration
- DCACHE_STATS_EN defined:
  - hit_count increments on each cached load hit accepted in IDLE.
  - miss_count increments on each entry to FILL.
  - Both counters saturate at 32'hFFFF_FFFF.
- DCACHE_STATS_EN undefined: both counters are constant 0 and no counter flops exist.

## Test plan
- **Load miss then hit**: reset, then lw 0x0001_0000 with ack 3 cycles after mem_req and mem_rdata=0x8BAD_F00D -> stall for 5 cycles, then rdata=0x8BAD_F00D. A second lw to the same address gives stall=0 and the same data.
- **Byte extension**: cached word 0x80FF_7F01. lb 0x0001_0003 -> 0xFFFF_FF80; lbu -> 0x0000_0080; lh 0x0001_0000 -> 0x0000_7F01; lhu 0x0001_0002 -> 0x0000_80FF.
- **LRU eviction**: with SET_BITS=3, load A=0x0001_0000 and B=0x0001_0020, then reload A, then load C=0x0001_0040 -> B is evicted. Reloading A hits; reloading B misses.
- **Store hit**: sb 0x0001_0002 with wdata 0xAB onto cached 0x1122_3344 -> mem_wstrb=0100, mem_wdata=0x00AB_0000. A later lw hits and returns 0x11AB_3344.
- **Uncached window**: two lw to 0x0000_00FC -> both issue mem_req and return the acked data. Neither allocates, and miss_count is unchanged.
- **Reset in FILL**: assert rst while mem_req=1 -> mem_req=0 next cycle. A late mem_ack is ignored, and the same address misses afterwards.
